// File: rtl/ttt_pkg.sv
// Shared types for the tic-tac-toe turn controller: FSM states and the
// 2-bit player / result codes used on turn, wr_player and who.
package ttt_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_TURN  = 3'd1,
      S_WRITE = 3'd2,
      S_CHECK = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [1:0] NONE = 2'b00;
   localparam logic [1:0] P1   = 2'b01;
   localparam logic [1:0] P2   = 2'b10;
   localparam logic [1:0] DRAW = 2'b11;

   // True when exactly one square is requested.
   function automatic logic is_onehot9(input logic [8:0] v);
      return (v != 9'd0) && ((v & (v - 9'd1)) == 9'd0);
   endfunction

endpackage

// File: rtl/turn_timer.sv
// Per-turn cycle counter: reloads to 0 on load, counts while enabled, and
// flags the last allowed cycle of a turn (count == TURN_CYCLES-1).
module turn_timer #(
   parameter int TURN_CYCLES = 10
) (
   input  logic clock1,
   input  logic reset,
   input  logic load,
   input  logic enable,
   output logic expired
);

   localparam int W = $clog2(TURN_CYCLES);
   localparam logic [W-1:0] CNT_LAST = W'(TURN_CYCLES - 1);
   localparam logic [W-1:0] CNT_ONE  = W'(1);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clock1 or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= '0;
      end else if (enable && cnt_q != CNT_LAST) begin
         cnt_q <= cnt_q + CNT_ONE;
      end
   end

   assign expired = enable && (cnt_q == CNT_LAST);

endmodule

// File: rtl/turn_controller.sv
// Tic-tac-toe turn sequencing: validates moves, strobes board writes, judges
// win/draw. Optional per-turn timeout enabled by defining TURN_TIMEOUT_EN.
module turn_controller
   import ttt_pkg::*;
#(
   parameter int TURN_CYCLES = 10
) (
   input  logic       clock1,
   input  logic       reset,
   input  logic       start,
   input  logic [8:0] Play1_en,
   input  logic [8:0] Play2_en,
   input  logic [8:0] occupied,
   input  logic       win,
   input  logic       no_space,
   output logic       board_clr,
   output logic       wr_en,
   output logic [8:0] wr_sel,
   output logic [1:0] wr_player,
   output logic [1:0] turn,
   output logic [1:0] who,
   output logic       illegal,
   output logic       timeout,
   output logic [2:0] dbg_state
);

   state_t     state_q, state_d;
   logic [1:0] cur_q, cur_d;
   logic [8:0] sel_q, sel_d;
   logic [1:0] who_q, who_d;
   logic       timeout_q, timeout_d;
   logic       clr_q, clr_d;
   logic       ill_q, ill_d;

   logic [8:0] req, other_req;
   logic [1:0] opponent;
   logic       legal;
   logic       timer_load;
   logic       timer_expired;

   assign req       = (cur_q == P1) ? Play1_en : Play2_en;
   assign other_req = (cur_q == P1) ? Play2_en : Play1_en;
   assign opponent  = (cur_q == P1) ? P2 : P1;
   assign legal     = is_onehot9(req) && ((req & occupied) == 9'd0);

`ifdef TURN_TIMEOUT_EN
   turn_timer #(
      .TURN_CYCLES(TURN_CYCLES)
   ) u_turn_timer (
      .clock1 (clock1),
      .reset  (reset),
      .load   (timer_load),
      .enable (state_q == S_TURN),
      .expired(timer_expired)
   );
`else
   // No timer: the comparison is constant false, so a turn never expires.
   assign timer_expired = (TURN_CYCLES < 0);
`endif

   always_ff @(posedge clock1 or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cur_q     <= NONE;
         sel_q     <= '0;
         who_q     <= NONE;
         timeout_q <= 1'b0;
         clr_q     <= 1'b0;
         ill_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cur_q     <= cur_d;
         sel_q     <= sel_d;
         who_q     <= who_d;
         timeout_q <= timeout_d;
         clr_q     <= clr_d;
         ill_q     <= ill_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cur_d      = cur_q;
      sel_d      = sel_q;
      who_d      = who_q;
      timeout_d  = timeout_q;
      clr_d      = 1'b0;
      ill_d      = 1'b0;
      timer_load = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d    = S_TURN;
               cur_d      = P1;
               who_d      = NONE;
               timeout_d  = 1'b0;
               clr_d      = 1'b1;
               timer_load = 1'b1;
            end
         end
         S_TURN: begin
            // An all-zero vector is "no request", not a rejected one.
            ill_d = ((req != 9'd0) && !legal) || (other_req != 9'd0);
            if (legal) begin
               state_d = S_WRITE;
               sel_d   = req;
            end else if (timer_expired) begin
               state_d   = S_DONE;
               who_d     = opponent;
               timeout_d = 1'b1;
            end
         end
         S_WRITE: state_d = S_CHECK;
         S_CHECK: begin
            if (win) begin
               state_d = S_DONE;
               who_d   = cur_q;
            end else if (no_space) begin
               state_d = S_DONE;
               who_d   = DRAW;
            end else begin
               state_d    = S_TURN;
               cur_d      = opponent;
               timer_load = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign board_clr = clr_q;
   assign wr_en     = (state_q == S_WRITE);
   assign wr_sel    = wr_en ? sel_q : 9'd0;
   assign wr_player = wr_en ? cur_q : NONE;
   assign turn      = (state_q == S_TURN) ? cur_q : NONE;
   assign who       = who_q;
   assign illegal   = ill_q;
   assign timeout   = timeout_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_turn_controller.sv
// Bench for turn_controller: vector table plus hand sequences for reset in
// WRITE and (with TURN_TIMEOUT_EN) turn expiry.
module tb_turn_controller;
   import ttt_pkg::*;

   logic       clock1 = 1'b0;
   logic       reset  = 1'b1;
   logic       start  = 1'b0;
   logic [8:0] Play1_en = '0;
   logic [8:0] Play2_en = '0;
   logic [8:0] occupied = '0;
   logic       win      = 1'b0;
   logic       no_space = 1'b0;
   logic       board_clr, wr_en, illegal, timeout;
   logic [8:0] wr_sel;
   logic [1:0] wr_player, turn, who;
   logic [2:0] dbg_state;

   turn_controller #(.TURN_CYCLES(10)) dut (
      .clock1   (clock1),
      .reset    (reset),
      .start    (start),
      .Play1_en (Play1_en),
      .Play2_en (Play2_en),
      .occupied (occupied),
      .win      (win),
      .no_space (no_space),
      .board_clr(board_clr),
      .wr_en    (wr_en),
      .wr_sel   (wr_sel),
      .wr_player(wr_player),
      .turn     (turn),
      .who      (who),
      .illegal  (illegal),
      .timeout  (timeout),
      .dbg_state(dbg_state)
   );

   always #5 clock1 = ~clock1;

   typedef struct {
      logic       st;
      logic [8:0] p1, p2, occ;
      logic       w, ns;
      logic       clr, wen;
      logic [8:0] sel;
      logic [1:0] wp, trn, res;
      logic       ill, to;
   } vec_t;

   localparam int W = 19;
   logic [W-1:0] exp_q[$];
   vec_t vecs[$];
   int n_vec  = 0;
   int n_miss = 0;

   function automatic logic [W-1:0] pack(input logic clr, input logic wen,
      input logic [8:0] sel, input logic [1:0] wp, input logic [1:0] trn,
      input logic [1:0] res, input logic ill, input logic to);
      return {clr, wen, sel, wp, trn, res, ill, to};
   endfunction

   function automatic vec_t mk(input logic st, input logic [8:0] p1,
      input logic [8:0] p2, input logic [8:0] occ, input logic w, input logic ns,
      input logic clr, input logic wen, input logic [8:0] sel, input logic [1:0] wp,
      input logic [1:0] trn, input logic [1:0] res, input logic ill, input logic to);
      vec_t v;
      v.st = st; v.p1 = p1; v.p2 = p2; v.occ = occ; v.w = w; v.ns = ns;
      v.clr = clr; v.wen = wen; v.sel = sel; v.wp = wp; v.trn = trn;
      v.res = res; v.ill = ill; v.to = to;
      return v;
   endfunction

   function automatic logic [W-1:0] dut_out();
      return pack(board_clr, wr_en, wr_sel, wr_player, turn, who, illegal, timeout);
   endfunction

   task automatic compare(input string tag);
      logic [W-1:0] got, e;
      got = dut_out();
      e   = exp_q.pop_front();
      n_vec++;
      if (got !== e) begin
         n_miss++;
         $display("FAIL %s: got %b expected %b (clr,wen,sel,wp,turn,who,ill,to)", tag, got, e);
      end
   endtask

   task automatic apply_vec(input vec_t v, input string tag);
      @(negedge clock1);
      start = v.st; Play1_en = v.p1; Play2_en = v.p2; occupied = v.occ;
      win = v.w; no_space = v.ns;
      exp_q.push_back(pack(v.clr, v.wen, v.sel, v.wp, v.trn, v.res, v.ill, v.to));
      @(posedge clock1);
      #1;
      compare(tag);
   endtask

   task automatic check_state(input string tag, input logic [2:0] exp_s);
      n_vec++;
      if (dbg_state !== exp_s) begin
         n_miss++;
         $display("FAIL %s: state got %0d expected %0d", tag, dbg_state, exp_s);
      end
   endtask

   initial begin
      // idle/none rows reused below
      vecs.push_back(mk(0, 9'h001, 0, 0, 0, 0,  0, 0, 0, NONE, NONE, NONE, 0, 0)); // idle ignores request
      vecs.push_back(mk(1, 0, 0, 0, 0, 0,       1, 0, 0, NONE, P1, NONE, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0,       0, 0, 0, NONE, P1, NONE, 0, 0));
      vecs.push_back(mk(0, 9'h003, 0, 0, 0, 0,  0, 0, 0, NONE, P1, NONE, 1, 0)); // two bits
      vecs.push_back(mk(0, 9'h001, 0, 9'h001, 0, 0, 0, 0, 0, NONE, P1, NONE, 1, 0)); // occupied
      vecs.push_back(mk(0, 0, 9'h010, 0, 0, 0,  0, 0, 0, NONE, P1, NONE, 1, 0)); // wrong player
      vecs.push_back(mk(0, 9'h001, 0, 0, 0, 0,  0, 1, 9'h001, P1, NONE, NONE, 0, 0));
      vecs.push_back(mk(0, 9'h002, 0, 0, 0, 0,  0, 0, 0, NONE, NONE, NONE, 0, 0)); // WRITE ignores
      vecs.push_back(mk(0, 0, 9'h004, 0, 0, 0,  0, 0, 0, NONE, P2, NONE, 0, 0));   // CHECK ignores
      vecs.push_back(mk(0, 0, 9'h010, 9'h001, 0, 0, 0, 1, 9'h010, P2, NONE, NONE, 0, 0));
      vecs.push_back(mk(0, 0, 9'h020, 0, 0, 0,  0, 0, 0, NONE, NONE, NONE, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0,       0, 0, 0, NONE, NONE, P2, 0, 0));   // P2 wins
      vecs.push_back(mk(0, 9'h004, 9'h008, 0, 0, 0, 0, 0, 0, NONE, NONE, P2, 0, 0)); // DONE ignores
      vecs.push_back(mk(1, 0, 0, 0, 0, 0,       1, 0, 0, NONE, P1, NONE, 0, 0));
      vecs.push_back(mk(0, 9'h100, 0, 0, 0, 0,  0, 1, 9'h100, P1, NONE, NONE, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0,       0, 0, 0, NONE, NONE, NONE, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1,       0, 0, 0, NONE, NONE, DRAW, 0, 0)); // draw
      vecs.push_back(mk(1, 0, 0, 0, 0, 0,       1, 0, 0, NONE, P1, NONE, 0, 0));
      vecs.push_back(mk(0, 9'h002, 0, 0, 0, 0,  0, 1, 9'h002, P1, NONE, NONE, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0,       0, 0, 0, NONE, NONE, NONE, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 1,       0, 0, 0, NONE, NONE, P1, 0, 0));   // win beats full
      vecs.push_back(mk(1, 9'h001, 0, 0, 0, 0,  1, 0, 0, NONE, P1, NONE, 0, 0));
      vecs.push_back(mk(0, 9'h008, 9'h001, 0, 0, 0, 0, 1, 9'h008, P1, NONE, NONE, 1, 0)); // both request
      vecs.push_back(mk(0, 0, 0, 0, 0, 0,       0, 0, 0, NONE, NONE, NONE, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0,       0, 0, 0, NONE, P2, NONE, 0, 0));
      vecs.push_back(mk(0, 9'h001, 0, 0, 0, 0,  0, 0, 0, NONE, P2, NONE, 1, 0));
      vecs.push_back(mk(0, 0, 9'h001, 9'h009, 0, 0, 0, 0, 0, NONE, P2, NONE, 1, 0));
      vecs.push_back(mk(0, 0, 9'h002, 9'h009, 0, 0, 0, 1, 9'h002, P2, NONE, NONE, 0, 0));

      // reset
      repeat (2) @(posedge clock1);
      @(negedge clock1);
      reset = 1'b0;
      #1;
      exp_q.push_back('0);
      compare("reset_outputs");
      check_state("reset_state", S_IDLE);

      foreach (vecs[i]) apply_vec(vecs[i], $sformatf("vec%0d", i));

      // asynchronous reset while the write strobe is up
      @(negedge clock1);
      check_state("in_write", S_WRITE);
      reset = 1'b1;
      Play1_en = '0; Play2_en = '0; occupied = '0;
      #1;
      exp_q.push_back('0);
      compare("reset_in_write");
      check_state("reset_in_write_state", S_IDLE);
      @(negedge clock1);
      reset = 1'b0;
      apply_vec(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, NONE, P1, NONE, 0, 0), "start_after_reset");

`ifdef TURN_TIMEOUT_EN
      for (int i = 1; i <= 9; i++) begin
         if (i == 5)
            apply_vec(mk(0, 9'h003, 0, 0, 0, 0, 0, 0, 0, NONE, P1, NONE, 1, 0), "wait_illegal");
         else
            apply_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, P1, NONE, 0, 0), $sformatf("wait%0d", i));
      end
      apply_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, NONE, P2, 0, 1), "timeout_fires");
      apply_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, NONE, P2, 0, 1), "timeout_holds");
      apply_vec(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, NONE, P1, NONE, 0, 0), "restart_clears_timeout");
      for (int i = 1; i <= 9; i++)
         apply_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, P1, NONE, 0, 0), $sformatf("wait_b%0d", i));
      apply_vec(mk(0, 9'h001, 0, 0, 0, 0, 0, 1, 9'h001, P1, NONE, NONE, 0, 0), "move_in_expiry_cycle");
`else
      for (int i = 1; i <= 12; i++)
         apply_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, P1, NONE, 0, 0), $sformatf("no_timeout%0d", i));
      apply_vec(mk(0, 9'h001, 0, 0, 0, 0, 0, 1, 9'h001, P1, NONE, NONE, 0, 0), "late_move");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
